// File: rtl/q26_accum_seq.sv
// Burst accumulator for signed Q2.6 samples: valid/ready in, registered
// result with sticky overflow out. Shared adder and incrementer cells included.
`timescale 1ns/1ps

module fixed_point_adder_signed (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       ovf
);
  assign sum = a + b;
  // Overflow only when both operands share a sign and the result flips it.
  assign ovf = (a[7] == b[7]) && (sum[7] != a[7]);
endmodule

module one_adder (
  input  logic [2:0] a,
  output logic [2:0] y
);
  assign y = a + 3'd1;
endmodule

module q26_accum_seq #(
  parameter int unsigned SATURATE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] len,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_ovf,
  input  logic       out_ready,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t     state, state_nx;
  logic [7:0] acc, acc_nx;
  logic [2:0] idx, idx_nx;
  logic [2:0] len_q, len_nx;
  logic       ovf_q, ovf_nx;

  logic [7:0] add_sum;
  logic       add_ovf;
  logic [2:0] idx_inc;
  logic       beat;

  fixed_point_adder_signed u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  one_adder u_inc (
    .a (idx),
    .y (idx_inc)
  );

  assign beat = in_valid & in_ready;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    idx_nx   = idx;
    len_nx   = len_q;
    ovf_nx   = ovf_q;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nx = ACCUM;
          len_nx   = len;
          acc_nx   = '0;
          idx_nx   = '0;
          ovf_nx   = 1'b0;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (beat) begin
          idx_nx = idx_inc;
          if (add_ovf) ovf_nx = 1'b1;
          // Operands agree in sign on overflow, so the sample's sign picks the rail.
          if (SATURATE != 0 && add_ovf) acc_nx = in_data[7] ? 8'h80 : 8'h7F;
          else                          acc_nx = add_sum;
          if (idx == len_q) state_nx = HOLD;
        end
      end
      HOLD: begin
        if (abort || out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      idx   <= idx_nx;
      len_q <= len_nx;
      ovf_q <= ovf_nx;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);
  assign out_data  = out_valid ? acc : 8'h00;
  assign out_ovf   = out_valid & ovf_q;
endmodule

// File: tb/tb_q26_accum_seq.sv
// Bench for q26_accum_seq: saturating and wrapping instances driven in lockstep,
// directed scenarios plus randomized bursts against an integer reference model.
`timescale 1ns/1ps

module tb_q26_accum_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] len = 3'd0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready_s, out_valid_s, out_ovf_s, busy_s;
  logic [7:0] out_data_s;
  logic       in_ready_w, out_valid_w, out_ovf_w, busy_w;
  logic [7:0] out_data_w;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] smp [8];

  always #5 clk = ~clk;

  q26_accum_seq #(.SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_data(out_data_s), .out_ovf(out_ovf_s),
    .out_ready(out_ready), .busy(busy_s)
  );

  q26_accum_seq #(.SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w),
    .out_valid(out_valid_w), .out_data(out_data_w), .out_ovf(out_ovf_w),
    .out_ready(out_ready), .busy(busy_w)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Sample one time unit after the rising edge; outputs then reflect the new state.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: integer running sum over the first n samples, clamped or wrapped.
  task automatic model(input int n, input bit sat, output logic [7:0] res, output bit ov);
    int acc;
    int v;
    acc = 0;
    ov  = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = acc + int'($signed(smp[i]));
      if (v > 127)       begin ov = 1'b1; acc = sat ? 127  : v - 256; end
      else if (v < -128) begin ov = 1'b1; acc = sat ? -128 : v + 256; end
      else               acc = v;
    end
    res = acc[7:0];
  endtask

  // Starts a burst from IDLE and feeds samples until len+1 are accepted.
  // mode 0: continuous valid, 1: valid toggles 1-0-1, 2: random valid.
  task automatic run_burst(input int ln, input int mode, output int beats,
                           output int cyc, output bit to);
    int   budget;
    logic rdy;
    budget = 200;
    beats  = 0;
    cyc    = 0;
    len    = ln[2:0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
    while (beats <= ln && budget > 0) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = smp[beats];
      rdy     = in_ready_s;
      tick();
      cyc++;
      budget--;
      if (in_valid && rdy) beats++;
    end
    in_valid = 1'b0;
    to = (budget == 0);
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_tests++;
    if ({in_ready_s, out_valid_s, busy_s, out_ovf_s, out_data_s} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_sat: outputs %h want 000",
               {in_ready_s, out_valid_s, busy_s, out_ovf_s, out_data_s});
    end
    n_tests++;
    if ({in_ready_w, out_valid_w, busy_w, out_ovf_w, out_data_w} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_wrap: outputs %h want 000",
               {in_ready_w, out_valid_w, busy_w, out_ovf_w, out_data_w});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy %b want 0", busy_s);
    end
  endtask

  task automatic test_basic;
    int beats, cyc;
    bit to;
    smp[0] = 8'h10; smp[1] = 8'h20; smp[2] = 8'h08; smp[3] = 8'h04;
    run_burst(3, 0, beats, cyc, to);
    n_tests++;
    if (to || cyc != 4 || out_valid_s !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: cycles %0d valid %b want 4 and 1", cyc, out_valid_s);
    end
    n_tests++;
    if (in_ready_s !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_low: in_ready %b want 0", in_ready_s);
    end
    n_tests++;
    if ({out_ovf_s, out_data_s} !== 9'h03C || {out_ovf_w, out_data_w} !== 9'h03C) begin
      n_fail++;
      $display("FAIL basic_sum: sat %h wrap %h want 03c",
               {out_ovf_s, out_data_s}, {out_ovf_w, out_data_w});
    end
    handshake();
    n_tests++;
    if ({busy_s, out_valid_s} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_release: busy,valid %b want 00", {busy_s, out_valid_s});
    end
  endtask

  task automatic test_pos_sat;
    int beats, cyc;
    bit to;
    smp[0] = 8'h60; smp[1] = 8'h60; smp[2] = 8'hF0;
    run_burst(2, 0, beats, cyc, to);
    n_tests++;
    if (to || {out_ovf_s, out_data_s} !== 9'h16F) begin
      n_fail++;
      $display("FAIL pos_sat: got %h want 16f", {out_ovf_s, out_data_s});
    end
    n_tests++;
    if ({out_ovf_w, out_data_w} !== 9'h1B0) begin
      n_fail++;
      $display("FAIL pos_wrap: got %h want 1b0", {out_ovf_w, out_data_w});
    end
    handshake();
  endtask

  task automatic test_neg_ovf;
    int beats, cyc;
    bit to;
    smp[0] = 8'h80; smp[1] = 8'hC0;
    run_burst(1, 0, beats, cyc, to);
    n_tests++;
    if (to || {out_ovf_s, out_data_s} !== 9'h180) begin
      n_fail++;
      $display("FAIL neg_sat: got %h want 180", {out_ovf_s, out_data_s});
    end
    n_tests++;
    if ({out_ovf_w, out_data_w} !== 9'h140) begin
      n_fail++;
      $display("FAIL neg_wrap: got %h want 140", {out_ovf_w, out_data_w});
    end
    handshake();
  endtask

  task automatic test_max_len_gaps;
    int beats, cyc;
    bit to;
    bit bad;
    for (int i = 0; i < 8; i++) smp[i] = 8'h01;
    run_burst(7, 1, beats, cyc, to);
    n_tests++;
    if (to || beats != 8 || {out_ovf_s, out_data_s} !== 9'h008) begin
      n_fail++;
      $display("FAIL maxlen_sum: beats %0d result %h want 8 and 008", beats, {out_ovf_s, out_data_s});
    end
    bad = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (in_ready_s !== 1'b0 || out_valid_s !== 1'b1 || out_data_s !== 8'h08) bad = 1'b1;
    end
    in_valid = 1'b0;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL maxlen_no_ninth: ready %b valid %b data %h want 0 1 08",
               in_ready_s, out_valid_s, out_data_s);
    end
    handshake();
    // Index wrapped to 0 after eight samples; a fresh single-sample burst must still work.
    smp[0] = 8'h05;
    run_burst(0, 0, beats, cyc, to);
    n_tests++;
    if (to || cyc != 1 || {out_ovf_s, out_data_s} !== 9'h005) begin
      n_fail++;
      $display("FAIL maxlen_next: cycles %0d result %h want 1 and 005", cyc, {out_ovf_s, out_data_s});
    end
    handshake();
  endtask

  task automatic test_backpressure;
    int beats, cyc;
    bit to, ov, bad;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) smp[i] = 8'($urandom);
    run_burst(3, 0, beats, cyc, to);
    model(4, 1'b1, exp, ov);
    bad = to;
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      tick();
      if (out_valid_s !== 1'b1 || out_data_s !== exp || out_ovf_s !== ov ||
          busy_s !== 1'b1 || in_ready_s !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_stable: valid %b data %h ovf %b want 1 %h %b",
               out_valid_s, out_data_s, out_ovf_s, exp, ov);
    end
    start = 1'b1;
    handshake();
    n_tests++;
    if ({busy_s, out_valid_s} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_release: busy,valid %b want 00", {busy_s, out_valid_s});
    end
    tick();
    start = 1'b0;
    n_tests++;
    if ({busy_s, in_ready_s} !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_restart: busy,ready %b want 11", {busy_s, in_ready_s});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort;
    int beats, cyc;
    bit to, bad;
    len = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    n_tests++;
    if ({busy_s, in_ready_s, out_valid_s} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_accum: busy,ready,valid %b want 000", {busy_s, in_ready_s, out_valid_s});
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid_s !== 1'b0 || busy_s !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL abort_quiet: valid %b busy %b want 0 0", out_valid_s, busy_s);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_tests++;
    if (busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start: busy %b want 0", busy_s);
    end
    smp[0] = 8'h40; smp[1] = 8'h40;
    run_burst(1, 0, beats, cyc, to);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (to || {busy_s, out_valid_s} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_hold: busy,valid %b want 00", {busy_s, out_valid_s});
    end
    // The overflow from the aborted burst must not leak into the next one.
    smp[0] = 8'h01;
    run_burst(0, 0, beats, cyc, to);
    n_tests++;
    if (to || {out_ovf_s, out_data_s} !== 9'h001) begin
      n_fail++;
      $display("FAIL abort_clean: got %h want 001", {out_ovf_s, out_data_s});
    end
    handshake();
  endtask

  task automatic test_async_reset;
    int beats, cyc;
    bit to;
    smp[0] = 8'h33; smp[1] = 8'h22;
    run_burst(1, 0, beats, cyc, to);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (to || {out_valid_s, busy_s, in_ready_s, out_ovf_s, out_data_s} !== 12'h000 ||
        {out_valid_w, busy_w, out_data_w} !== 10'h000) begin
      n_fail++;
      $display("FAIL async_reset: sat %h wrap %h want 000",
               {out_valid_s, busy_s, in_ready_s, out_ovf_s, out_data_s},
               {out_valid_w, busy_w, out_data_w});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({busy_s, out_valid_s} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_after: busy,valid %b want 00", {busy_s, out_valid_s});
    end
  endtask

  task automatic test_random;
    int beats, cyc, ln, w;
    bit to, ov_s, ov_w;
    logic [7:0] r_s, r_w;
    for (int b = 0; b < 30; b++) begin
      ln = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++)
        smp[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 31) + 8'h50);
      model(ln + 1, 1'b1, r_s, ov_s);
      model(ln + 1, 1'b0, r_w, ov_w);
      run_burst(ln, 2, beats, cyc, to);
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) tick();
      n_tests++;
      if (to || beats != ln + 1 || out_valid_s !== 1'b1 ||
          {out_ovf_s, out_data_s} !== {ov_s, r_s}) begin
        n_fail++;
        $display("FAIL rand_sat[%0d]: len %0d beats %0d got %h want %h",
                 b, ln, beats, {out_ovf_s, out_data_s}, {ov_s, r_s});
      end
      n_tests++;
      if ({out_ovf_w, out_data_w} !== {ov_w, r_w}) begin
        n_fail++;
        $display("FAIL rand_wrap[%0d]: got %h want %h", b, {out_ovf_w, out_data_w}, {ov_w, r_w});
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_ovf();
    test_max_len_gaps();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
